clk_div_multi: RTL and testbench
================================

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent divider channels, range 1..8.
REQ-002 Parameter CNT_W, default 26: divisor and counter width in bits.
REQ-003 Parameter DEFAULT_DIV, default 25000000: divisor loaded into every channel at reset; must fit in CNT_W bits.
REQ-004 clk  input  1: single system clock; all logic on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 en  input  NUM_CH: per-channel count enable.
REQ-007 div_load  input  1: one-cycle strobe writing div_val into channel div_sel.
REQ-008 div_sel  input  max(1,$clog2(NUM_CH)): channel index for div_load.
REQ-009 div_val  input  CNT_W: new divisor; 0 is treated as 1.
REQ-010 tick  output  NUM_CH: registered one-cycle pulse per channel at each terminal count.
REQ-011 clk_out  output  NUM_CH: registered square wave per channel, toggling on each tick.

Function
REQ-012 Each channel SHALL hold an unsigned counter cnt[CNT_W-1:0] and an active divisor D.
REQ-013 On an edge with en[i]=1 and cnt!=D-1, cnt SHALL increment by 1, and tick[i] SHALL be 0 after that edge.
REQ-014 On an edge with en[i]=1 and cnt==D-1, cnt SHALL become 0, tick[i] SHALL become 1 and clk_out[i] SHALL invert.
REQ-015 With en[i]=0, cnt and clk_out[i] SHALL hold and tick[i] SHALL be 0.
REQ-016 Latency: from cnt=0 with en held high, tick[i] SHALL first be high after exactly D rising edges; the tick period is D cycles and the clk_out period is 2*D cycles.
REQ-017 With D=1, tick[i] SHALL be high every enabled cycle and clk_out[i] SHALL toggle every enabled cycle.
REQ-018 A div_load with div_sel >= NUM_CH SHALL be ignored.
REQ-019 Channels SHALL be fully independent; a load to one channel SHALL not disturb the others.
REQ-020 The counter SHALL never exceed D-1 and SHALL never wrap through 2^CNT_W.

Reset
REQ-021 With rst=1 at an edge: cnt=0, tick=0, clk_out=0 and D=DEFAULT_DIV for all channels, overriding en and div_load.
REQ-022 Reset asserted mid-count SHALL discard the partial count; counting restarts from 0 on the first enabled edge after rst falls.

Configuration
REQ-023 Macro CLKDIV_SHADOW_EN selects the divisor-update policy.
REQ-024 Without CLKDIV_SHADOW_EN, a valid div_load SHALL update D immediately at that edge, set cnt=0, set clk_out[i]=0 and force tick[i]=0, even if a terminal count coincides (load wins).
REQ-025 With CLKDIV_SHADOW_EN, a valid div_load SHALL write a per-channel shadow register only.
REQ-026 With CLKDIV_SHADOW_EN, D SHALL take the shadow value at the next terminal-count edge, so the current period completes glitch-free.
REQ-027 With CLKDIV_SHADOW_EN, if a load coincides with a terminal count on the same channel, D SHALL take div_val directly and the tick SHALL still occur.
REQ-028 With CLKDIV_SHADOW_EN, the shadow registers SHALL reset to DEFAULT_DIV.

Verification
REQ-029 Reset, load D=4 on ch0, en=01 for 20 cycles -> tick[0] high on cycles 4, 8, 12, 16, 20; clk_out[0] period 8; ch1 tick stays 0.
REQ-030 Load div_val=0 and div_val=1 on ch1, en[1]=1 -> tick[1] high every cycle and clk_out[1] toggles every cycle in both cases.
REQ-031 D=5, deassert en[0] for 3 cycles mid-count at cnt=2 -> tick delayed exactly 3 cycles and clk_out holds its level.
REQ-032 Load D=3 at cnt=6 of D=10 -> without macro: restart and next tick 3 cycles later; with macro: tick at cnt=9, then a 3-cycle period.
REQ-033 Assert rst at cnt=7 of D=10, then release -> all outputs 0, D=DEFAULT_DIV, and a div_load with div_sel=NUM_CH has no effect.

Source files
------------

// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi: per-channel enables, divisor load strobe,
// and the registered tick / clk_out outputs.
interface clk_div_multi_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 26
);
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en;
    logic              div_load;
    logic [SEL_W-1:0]  div_sel;
    logic [CNT_W-1:0]  div_val;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;

    modport master (
        output en, div_load, div_sel, div_val,
        input  tick, clk_out
    );

    modport slave (
        input  en, div_load, div_sel, div_val,
        output tick, clk_out
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel tick pulse and square wave.
// Define CLKDIV_SHADOW_EN to defer divisor loads to the next terminal count.
module clk_div_multi #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input logic            clk,
    input logic            rst,
    clk_div_multi_if.slave bus
);
    localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] div_q, div_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic [NUM_CH-1:0]            clk_q, clk_d;
    logic [NUM_CH-1:0]            load_hit;
    logic [NUM_CH-1:0]            term;
    logic [CNT_W-1:0]             load_val;
`ifdef CLKDIV_SHADOW_EN
    logic [NUM_CH-1:0][CNT_W-1:0] shadow_q, shadow_d;
`endif

    // A zero divisor behaves as divide-by-one.
    assign load_val = (bus.div_val == '0) ? CNT_W'(1) : bus.div_val;

    // Out-of-range selects match no channel, so they are dropped naturally.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            load_hit[i] = bus.div_load && (32'(bus.div_sel) == i);
            term[i]     = bus.en[i] && (cnt_q[i] == div_q[i] - CNT_W'(1));
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = '0;
        clk_d  = clk_q;
`ifdef CLKDIV_SHADOW_EN
        shadow_d = shadow_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (load_hit[i]) begin
                shadow_d[i] = load_val;
            end
            if (term[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                clk_d[i]  = ~clk_q[i];
                // A load landing on the terminal edge takes effect straight away.
                div_d[i]  = load_hit[i] ? load_val : shadow_q[i];
            end else if (bus.en[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
`else
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (load_hit[i]) begin
                // Load wins over a coincident terminal count.
                div_d[i] = load_val;
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
            end else if (term[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                clk_d[i]  = ~clk_q[i];
            end else if (bus.en[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= {NUM_CH{DefDiv}};
            tick_q <= '0;
            clk_q  <= '0;
`ifdef CLKDIV_SHADOW_EN
            shadow_q <= {NUM_CH{DefDiv}};
`endif
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
`ifdef CLKDIV_SHADOW_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    assign bus.tick    = tick_q;
    assign bus.clk_out = clk_q;
endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: cycle-level reference model plus directed
// scenarios with hand-computed tick patterns; follows CLKDIV_SHADOW_EN if defined.
module tb_clk_div_multi;
    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 8;
    localparam int unsigned DEF = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clk_div_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    clk_div_multi #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Reference model: each channel tracks enabled edges remaining until its next tick.
    int m_rem [NCH];
    int m_div [NCH];
    int m_sh  [NCH];
    bit m_tick[NCH];
    bit m_clk [NCH];
    bit ld;
    int nv;

    always @(posedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (rst) begin
                m_div[ch] = DEF; m_sh[ch] = DEF; m_rem[ch] = DEF;
                m_tick[ch] = 0;  m_clk[ch] = 0;
            end else begin
                ld = bus.div_load && (int'(bus.div_sel) == ch);
                nv = (bus.div_val == 0) ? 1 : int'(bus.div_val);
                m_tick[ch] = 0;
`ifdef CLKDIV_SHADOW_EN
                if (ld) m_sh[ch] = nv;
                if (bus.en[ch]) begin
                    m_rem[ch]--;
                    if (m_rem[ch] == 0) begin
                        m_tick[ch] = 1;
                        m_clk[ch]  = !m_clk[ch];
                        m_div[ch]  = ld ? nv : m_sh[ch];
                        m_rem[ch]  = m_div[ch];
                    end
                end
`else
                if (ld) begin
                    m_div[ch] = nv; m_rem[ch] = nv; m_clk[ch] = 0;
                end else if (bus.en[ch]) begin
                    m_rem[ch]--;
                    if (m_rem[ch] == 0) begin
                        m_tick[ch] = 1;
                        m_clk[ch]  = !m_clk[ch];
                        m_rem[ch]  = m_div[ch];
                    end
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int ch = 0; ch < NCH; ch++) begin
                total++;
                if (bus.tick[ch] !== m_tick[ch]) begin
                    bad++;
                    $display("FAIL model tick[%0d] t=%0t: got %b expected %b",
                             ch, $time, bus.tick[ch], m_tick[ch]);
                end
                total++;
                if (bus.clk_out[ch] !== m_clk[ch]) begin
                    bad++;
                    $display("FAIL model clk_out[%0d] t=%0t: got %b expected %b",
                             ch, $time, bus.clk_out[ch], m_clk[ch]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [NCH-1:0] e, input logic l,
                       input logic [1:0] sel, input logic [CW-1:0] val);
        @(negedge clk);
        rst = r; bus.en = e; bus.div_load = l; bus.div_sel = sel; bus.div_val = val;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [NCH-1:0] e);
        cyc(1'b0, e, 1'b0, 2'd0, '0);
    endtask

    logic [19:0] h20;
    logic [11:0] h12;
    logic [9:0]  h10;
    logic [4:0]  h5;
    logic        t1;
    int          n;
    logic [9:0]  pat31;

    initial begin
        bus.en = '0; bus.div_load = 1'b0; bus.div_sel = '0; bus.div_val = '0;

        cyc(1'b1, '0, 1'b0, 2'd0, '0);
        chk_on = 1'b1;
        check("reset tick", 32'(bus.tick), 32'd0);
        check("reset clk_out", 32'(bus.clk_out), 32'd0);

        // Divide-by-4 on ch0 over 20 enabled edges.
        cyc(1'b0, '0, 1'b1, 2'd0, 8'd4);
        h20 = '0; t1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            run(3'b001);
            h20[k] = bus.tick[0];
            t1 |= bus.tick[1];
        end
`ifdef CLKDIV_SHADOW_EN
        check("div4 tick pattern", 32'(h20), 32'h11110);
        check("div4 clk_out end", 32'(bus.clk_out[0]), 32'd0);
`else
        check("div4 tick pattern", 32'(h20), 32'h88888);
        check("div4 clk_out end", 32'(bus.clk_out[0]), 32'd1);
`endif
        check("ch1 idle tick", 32'(t1), 32'd0);

        // div_val=0 then div_val=1 on ch1.
        cyc(1'b0, 3'b010, 1'b1, 2'd1, 8'd0);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            run(3'b010);
            n += int'(bus.tick[1]);
        end
`ifdef CLKDIV_SHADOW_EN
        check("div0 ticks", 32'(n), 32'd5);
`else
        check("div0 ticks", 32'(n), 32'd8);
`endif
        cyc(1'b0, 3'b010, 1'b1, 2'd1, 8'd1);
        n = int'(bus.tick[1]);
        for (int k = 0; k < 4; k++) begin
            run(3'b010);
            n += int'(bus.tick[1]);
        end
`ifdef CLKDIV_SHADOW_EN
        check("div1 ticks", 32'(n), 32'd5);
`else
        check("div1 ticks", 32'(n), 32'd4);
`endif

        // D=5 with a 3-edge enable gap at cnt=2.
        cyc(1'b1, '0, 1'b0, 2'd0, '0);
        pat31 = 10'b11111_00011;
        h10 = '0;
        for (int k = 0; k < 10; k++) begin
            run({2'b00, pat31[k]});
            h10[k] = bus.tick[0];
        end
        check("gap tick pattern", 32'(h10), 32'h080);
        check("gap clk_out end", 32'(bus.clk_out[0]), 32'd1);

        // Load D=3 at cnt=6 of D=10, ch1 running alongside.
        cyc(1'b1, '0, 1'b0, 2'd0, '0);
        cyc(1'b0, '0, 1'b1, 2'd0, 8'd10);
`ifdef CLKDIV_SHADOW_EN
        repeat (5) run(3'b001);
`endif
        repeat (6) run(3'b011);
        cyc(1'b0, 3'b011, 1'b1, 2'd0, 8'd3);
        h12 = '0;
        h12[0] = bus.tick[0];
        for (int k = 1; k < 12; k++) begin
            run(3'b011);
            h12[k] = bus.tick[0];
        end
        check("reload tick pattern", 32'(h12), 32'h248);

        // Reset at cnt=7 of D=10 overrides en and load; out-of-range load ignored.
        cyc(1'b1, '0, 1'b0, 2'd0, '0);
        cyc(1'b0, '0, 1'b1, 2'd0, 8'd10);
`ifdef CLKDIV_SHADOW_EN
        repeat (5) run(3'b001);
`endif
        repeat (7) run(3'b001);
        cyc(1'b1, 3'b111, 1'b1, 2'd0, 8'd3);
        check("mid reset tick", 32'(bus.tick), 32'd0);
        check("mid reset clk_out", 32'(bus.clk_out), 32'd0);
        cyc(1'b0, 3'b111, 1'b1, 2'd3, 8'd2);
        h5 = '0;
        h5[0] = bus.tick[0];
        for (int k = 1; k < 5; k++) begin
            run(3'b111);
            h5[k] = bus.tick[0];
        end
        check("post reset tick pattern", 32'(h5), 32'h10);
        check("post reset all tick", 32'(bus.tick), 32'h7);
        check("post reset clk_out", 32'(bus.clk_out), 32'h7);

        run('0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
